// File: rtl/aska_pkg.sv
// Shared definitions for the ASKA stimulation scheduler and pulse engine:
// FSM state encoding, electrode/amplitude widths and an index-width helper.
`timescale 1ns/1ps

package aska_pkg;

  // Electrode count and mask width, shared with the pulse engine.
  localparam int ELEC_NUM = 32;
  localparam int ELEC_W   = ELEC_NUM;
  // Amplitude DAC code width.
  localparam int AMP_W    = 6;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SELECT    = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } sched_state_e;

  // Width of a channel index. This is never less than 1, so a
  // single-channel build still has a legal vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aska_sched_pick.sv
// Rotating-base priority picker. It returns the first pending channel at or
// after base. The search wraps past the top index back to channel 0.
`timescale 1ns/1ps

module aska_sched_pick
  import aska_pkg::*;
#(
  parameter int  N_CH = 4,
  localparam int CH_W = idx_w(N_CH)
) (
  input  logic [N_CH-1:0] pending,
  input  logic [CH_W-1:0] base,
  output logic [CH_W-1:0] index,
  output logic            valid
);

  // Walk from the farthest offset back to the base, so the nearest hit wins.
  always_comb begin
    int j;
    // NOTE: every combinational output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    index = '0;
    valid = 1'b0;
    j     = 0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      j = int'(base) + k;
      if (j >= N_CH) j = j - N_CH;
      if (pending[j]) begin
        index = CH_W'(j);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aska_stim_scheduler.sv
// ASKA multi-channel stimulation scheduler. A frame counter raises
// frame_start. At each frame the enabled channels are snapshotted, and each
// one is served in turn on the shared biphasic pulse engine, with an
// inter-pulse gap after every pulse.
// Build option: define ASKA_SCHED_ROTATE_EN to rotate the first-served
// channel by one on every frame_start.
`timescale 1ns/1ps

module aska_stim_scheduler
  import aska_pkg::*;
#(
  parameter int  N_CH   = 4,
  parameter int  ELEC_W = aska_pkg::ELEC_W,
  parameter int  AMP_W  = aska_pkg::AMP_W,
  parameter int  PER_W  = 12,
  parameter int  GAP_W  = 4,
  localparam int CH_W   = idx_w(N_CH)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic [N_CH-1:0]          ch_enable,
  input  logic [N_CH*ELEC_W-1:0]   ch_electrode1,
  input  logic [N_CH*ELEC_W-1:0]   ch_electrode2,
  input  logic [N_CH*AMP_W-1:0]    ch_amplitude,
  input  logic [PER_W-1:0]         frame_period,
  input  logic [GAP_W-1:0]         gap,
  input  logic                     pulse_done,
  output logic                     pulse_start,
  output logic [CH_W-1:0]          pulse_ch,
  output logic [ELEC_W-1:0]        electrode1,
  output logic [ELEC_W-1:0]        electrode2,
  output logic [AMP_W-1:0]         amplitude,
  output logic                     frame_start,
  output logic                     frame_overrun,
  output logic                     active
);

  sched_state_e      state_q, state_d;
  logic [PER_W-1:0]  count_q, count_d;
  logic [N_CH-1:0]   pending_q, pending_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              overrun_q, overrun_d;
  logic [CH_W-1:0]   base;
  logic [CH_W-1:0]   pick_idx;
  logic              pick_valid;
  logic              served;

  assign frame_start   = enable && (count_q == frame_period);
  assign frame_overrun = overrun_q;
  assign served        = (state_q == ST_WAIT_DONE) && pulse_done;

`ifdef ASKA_SCHED_ROTATE_EN
  logic [CH_W-1:0] base_q;

  // The priority base advances on every frame boundary and wraps at N_CH.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)          base_q <= '0;
    else if (frame_start) base_q <= (base_q == CH_W'(N_CH - 1)) ? '0 : base_q + 1'b1;
  end
  assign base = base_q;
`else
  assign base = '0;
`endif

  aska_sched_pick #(.N_CH(N_CH)) u_pick (
    .pending (pending_q),
    .base    (base),
    .index   (pick_idx),
    .valid   (pick_valid)
  );

  // Next-state logic for the frame counter, pending set, gap timer and
  // overrun flag.
  always_comb begin
    count_d   = count_q + 1'b1;
    pending_d = pending_q;
    gap_cnt_d = gap_cnt_q;
    overrun_d = overrun_q;
    if (!enable || frame_start) count_d = '0;

    if (!enable)          pending_d = '0;
    else if (frame_start) pending_d = ch_enable;
    else if (served)      pending_d[pulse_ch] = 1'b0;

    // The GAP state lasts exactly gap cycles, so the timer loads gap-1.
    if (served)                                      gap_cnt_d = gap - 1'b1;
    else if (state_q == ST_GAP && gap_cnt_q != '0)   gap_cnt_d = gap_cnt_q - 1'b1;

    overrun_d = enable && (overrun_q || (frame_start && state_q != ST_IDLE));
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (frame_start) state_d = ST_SELECT;
      ST_SELECT:    state_d = (enable && pick_valid) ? ST_START : ST_IDLE;
      ST_START:     state_d = enable ? ST_WAIT_DONE : ST_IDLE;
      ST_WAIT_DONE: if (pulse_done) begin
                      if (!enable)         state_d = ST_IDLE;
                      else if (gap == '0)  state_d = ST_SELECT;
                      else                 state_d = ST_GAP;
                    end
      ST_GAP:       if (!enable)                state_d = ST_IDLE;
                    else if (gap_cnt_q == '0)   state_d = ST_SELECT;
      default:      state_d = ST_IDLE;
    endcase
  end

  // State and control registers.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of process order.
    if (!resetn) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      pending_q <= '0;
      gap_cnt_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      gap_cnt_q <= gap_cnt_d;
      overrun_q <= overrun_d;
    end
  end

  // Latch the selected channel's fields in SELECT. They hold through IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pulse_ch   <= '0;
      electrode1 <= '0;
      electrode2 <= '0;
      amplitude  <= '0;
    end else if (state_q == ST_SELECT && enable && pick_valid) begin
      pulse_ch   <= pick_idx;
      electrode1 <= ch_electrode1[int'(pick_idx) * ELEC_W +: ELEC_W];
      electrode2 <= ch_electrode2[int'(pick_idx) * ELEC_W +: ELEC_W];
      amplitude  <= ch_amplitude[int'(pick_idx) * AMP_W +: AMP_W];
    end
  end

  // FSM outputs. The engine is never started while enable is low.
  always_comb begin
    pulse_start = (state_q == ST_START) && enable;
    active      = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_aska_stim_scheduler.sv
// Directed testbench for aska_stim_scheduler. The scenarios cover ordering,
// sparse enables, overrun, enable drop, rotation and reset in the middle of
// the gap.
`timescale 1ns/1ps

module tb_aska_stim_scheduler;

  localparam int N_CH = 4, ELEC_W = 32, AMP_W = 6, PER_W = 12, GAP_W = 4;

  logic                   clk = 1'b0;
  logic                   resetn;
  logic                   enable;
  logic [N_CH-1:0]        ch_enable;
  logic [N_CH*ELEC_W-1:0] ch_electrode1, ch_electrode2;
  logic [N_CH*AMP_W-1:0]  ch_amplitude;
  logic [PER_W-1:0]       frame_period;
  logic [GAP_W-1:0]       gap;
  logic                   pulse_done;
  logic                   pulse_start;
  logic [1:0]             pulse_ch;
  logic [ELEC_W-1:0]      electrode1, electrode2;
  logic [AMP_W-1:0]       amplitude;
  logic                   frame_start, frame_overrun, active;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int eng_d = 10;

  int                ps_cyc[$];
  int                ps_ch[$];
  logic [ELEC_W-1:0] ps_e1[$], ps_e2[$];
  logic [AMP_W-1:0]  ps_amp[$];

  aska_stim_scheduler #(
    .N_CH(N_CH), .ELEC_W(ELEC_W), .AMP_W(AMP_W), .PER_W(PER_W), .GAP_W(GAP_W)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .ch_enable(ch_enable),
    .ch_electrode1(ch_electrode1), .ch_electrode2(ch_electrode2),
    .ch_amplitude(ch_amplitude), .frame_period(frame_period), .gap(gap),
    .pulse_done(pulse_done), .pulse_start(pulse_start), .pulse_ch(pulse_ch),
    .electrode1(electrode1), .electrode2(electrode2), .amplitude(amplitude),
    .frame_start(frame_start), .frame_overrun(frame_overrun), .active(active)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [ELEC_W-1:0] exp_e1(input int i);
    return 32'h1111_0000 + ELEC_W'(i);
  endfunction
  function automatic logic [ELEC_W-1:0] exp_e2(input int i);
    return 32'h2222_0000 + ELEC_W'(i * 16);
  endfunction
  function automatic logic [AMP_W-1:0] exp_amp(input int i);
    return AMP_W'(10 + i);
  endfunction

  // Log every engine start with its cycle and the latched channel fields.
  initial forever begin
    @(negedge clk);
    if (pulse_start === 1'b1) begin
      ps_cyc.push_back(cyc);
      ps_ch.push_back(int'(pulse_ch));
      ps_e1.push_back(electrode1);
      ps_e2.push_back(electrode2);
      ps_amp.push_back(amplitude);
    end
  end

  // Engine model: pulse_done is high for one cycle, eng_d cycles after the
  // pulse_start cycle.
  initial begin
    pulse_done = 1'b0;
    forever begin
      @(negedge clk);
      if (pulse_start === 1'b1) begin
        repeat (eng_d) @(posedge clk);
        #1 pulse_done = 1'b1;
        @(posedge clk);
        #1 pulse_done = 1'b0;
      end
    end
  end

  task automatic clear_log();
    ps_cyc.delete(); ps_ch.delete(); ps_e1.delete(); ps_e2.delete(); ps_amp.delete();
  endtask

  task automatic do_reset();
    resetn = 1'b0; enable = 1'b0; ch_enable = '0; gap = '0; frame_period = '0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    clear_log();
  endtask

  // Returns at the negedge of the next frame_start cycle, bounded.
  task automatic wait_fs(output int fs, output bit ok);
    ok = 1'b0;
    fs = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        ok = 1'b1;
        fs = cyc;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (pulse_start !== 1'b0)    begin bad++; $display("FAIL reset_pulse_start got=%b exp=0", pulse_start); end
    total++; if (pulse_ch !== 2'd0)       begin bad++; $display("FAIL reset_pulse_ch got=%0d exp=0", pulse_ch); end
    total++; if (electrode1 !== '0)       begin bad++; $display("FAIL reset_electrode1 got=%h exp=0", electrode1); end
    total++; if (electrode2 !== '0)       begin bad++; $display("FAIL reset_electrode2 got=%h exp=0", electrode2); end
    total++; if (amplitude !== '0)        begin bad++; $display("FAIL reset_amplitude got=%h exp=0", amplitude); end
    total++; if (frame_start !== 1'b0)    begin bad++; $display("FAIL reset_frame_start got=%b exp=0", frame_start); end
    total++; if (frame_overrun !== 1'b0)  begin bad++; $display("FAIL reset_overrun got=%b exp=0", frame_overrun); end
    total++; if (active !== 1'b0)         begin bad++; $display("FAIL reset_active got=%b exp=0", active); end
  endtask

  task automatic test_all_channels();
    int fs; bit ok;
    do_reset();
    frame_period = 12'd199; gap = 4'd2; eng_d = 10; ch_enable = 4'hF; enable = 1'b1;
    wait_fs(fs, ok);
    total++; if (!ok) begin bad++; $display("FAIL all_frame_start got=none exp=strobe"); end
    repeat (70) @(negedge clk);
    total++; if (ps_cyc.size() !== 4) begin bad++; $display("FAIL all_count got=%0d exp=4", ps_cyc.size()); end
    for (int i = 0; i < 4 && i < ps_cyc.size(); i++) begin
      total++; if (ps_cyc[i] !== fs + 2 + 14 * i) begin bad++; $display("FAIL all_time%0d got=%0d exp=%0d", i, ps_cyc[i], fs + 2 + 14 * i); end
      total++; if (ps_ch[i] !== i)               begin bad++; $display("FAIL all_ch%0d got=%0d exp=%0d", i, ps_ch[i], i); end
      total++; if (ps_e1[i] !== exp_e1(i))       begin bad++; $display("FAIL all_e1_%0d got=%h exp=%h", i, ps_e1[i], exp_e1(i)); end
      total++; if (ps_e2[i] !== exp_e2(i))       begin bad++; $display("FAIL all_e2_%0d got=%h exp=%h", i, ps_e2[i], exp_e2(i)); end
      total++; if (ps_amp[i] !== exp_amp(i))     begin bad++; $display("FAIL all_amp%0d got=%h exp=%h", i, ps_amp[i], exp_amp(i)); end
    end
    total++; if (frame_overrun !== 1'b0) begin bad++; $display("FAIL all_overrun got=%b exp=0", frame_overrun); end
    total++; if (active !== 1'b0)        begin bad++; $display("FAIL all_idle got=%b exp=0", active); end
    total++; if (electrode1 !== exp_e1(3)) begin bad++; $display("FAIL all_hold_e1 got=%h exp=%h", electrode1, exp_e1(3)); end
    enable = 1'b0;
  endtask

  task automatic test_sparse();
    int fs; bit ok;
    do_reset();
    frame_period = 12'd199; gap = 4'd2; eng_d = 10; ch_enable = 4'b0101; enable = 1'b1;
    wait_fs(fs, ok);
    total++; if (!ok) begin bad++; $display("FAIL sparse_frame_start got=none exp=strobe"); end
    repeat (60) @(negedge clk);
    total++; if (ps_cyc.size() !== 2) begin bad++; $display("FAIL sparse_count got=%0d exp=2", ps_cyc.size()); end
    if (ps_cyc.size() >= 2) begin
      total++; if (ps_ch[0] !== 0 || ps_ch[1] !== 2) begin bad++; $display("FAIL sparse_order got=%0d,%0d exp=0,2", ps_ch[0], ps_ch[1]); end
      total++; if (ps_cyc[1] - ps_cyc[0] !== 14)   begin bad++; $display("FAIL sparse_spacing got=%0d exp=14", ps_cyc[1] - ps_cyc[0]); end
      total++; if (ps_amp[1] !== exp_amp(2))       begin bad++; $display("FAIL sparse_amp got=%h exp=%h", ps_amp[1], exp_amp(2)); end
    end
    enable = 1'b0;
  endtask

  task automatic test_empty_frame();
    int fs; bit ok;
    do_reset();
    frame_period = 12'd9; gap = 4'd0; ch_enable = 4'h0; enable = 1'b1;
    wait_fs(fs, ok);
    total++; if (!ok) begin bad++; $display("FAIL empty_frame_start got=none exp=strobe"); end
    @(negedge clk);
    total++; if (active !== 1'b1) begin bad++; $display("FAIL empty_select got=%b exp=1", active); end
    @(negedge clk);
    total++; if (active !== 1'b0) begin bad++; $display("FAIL empty_back_idle got=%b exp=0", active); end
    repeat (25) @(negedge clk);
    total++; if (ps_cyc.size() !== 0)    begin bad++; $display("FAIL empty_no_pulse got=%0d exp=0", ps_cyc.size()); end
    total++; if (frame_overrun !== 1'b0) begin bad++; $display("FAIL empty_overrun got=%b exp=0", frame_overrun); end
    enable = 1'b0;
  endtask

  task automatic test_overrun();
    int fs, fs2; bit ok, ok2;
    do_reset();
    frame_period = 12'd20; gap = 4'd2; eng_d = 10; ch_enable = 4'hF; enable = 1'b1;
    wait_fs(fs, ok);
    total++; if (!ok) begin bad++; $display("FAIL ovr_frame_start got=none exp=strobe"); end
    wait_fs(fs2, ok2);
    total++; if (fs2 - fs !== 21) begin bad++; $display("FAIL ovr_period got=%0d exp=21", fs2 - fs); end
    total++; if (frame_overrun !== 1'b0) begin bad++; $display("FAIL ovr_before got=%b exp=0", frame_overrun); end
    @(posedge clk); #1;
    total++; if (frame_overrun !== 1'b1) begin bad++; $display("FAIL ovr_rise got=%b exp=1", frame_overrun); end
    repeat (100) @(negedge clk);
    total++; if (frame_overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b exp=1", frame_overrun); end
    enable = 1'b0;
    @(posedge clk); #1;
    total++; if (frame_overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", frame_overrun); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_enable_drop();
    int fs, done_cyc; bit ok, seen;
    do_reset();
    frame_period = 12'd199; gap = 4'd2; eng_d = 10; ch_enable = 4'hF; enable = 1'b1;
    wait_fs(fs, ok);
    total++; if (!ok) begin bad++; $display("FAIL drop_frame_start got=none exp=strobe"); end
    repeat (20) @(negedge clk);
    enable = 1'b0;
    seen = 1'b0; done_cyc = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (pulse_done === 1'b1) begin seen = 1'b1; done_cyc = cyc; end
    end
    total++; if (done_cyc !== fs + 26) begin bad++; $display("FAIL drop_done_time got=%0d exp=%0d", done_cyc, fs + 26); end
    total++; if (active !== 1'b1)      begin bad++; $display("FAIL drop_active_at_done got=%b exp=1", active); end
    @(negedge clk);
    total++; if (active !== 1'b0)      begin bad++; $display("FAIL drop_active_after got=%b exp=0", active); end
    repeat (60) @(negedge clk);
    total++; if (ps_cyc.size() !== 2)  begin bad++; $display("FAIL drop_no_more_pulses got=%0d exp=2", ps_cyc.size()); end
    total++; if (pulse_ch !== 2'd1)    begin bad++; $display("FAIL drop_hold_ch got=%0d exp=1", pulse_ch); end
  endtask

  task automatic test_rotation();
    int fs, exp_ch; bit ok;
    do_reset();
    frame_period = 12'd99; gap = 4'd2; eng_d = 10; ch_enable = 4'hF; enable = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_fs(fs, ok);
      total++; if (!ok) begin bad++; $display("FAIL rot_frame%0d got=none exp=strobe", f); end
      repeat (2) @(negedge clk);
`ifdef ASKA_SCHED_ROTATE_EN
      exp_ch = f + 1;
`else
      exp_ch = 0;
`endif
      total++; if (pulse_start !== 1'b1 || int'(pulse_ch) !== exp_ch) begin
        bad++; $display("FAIL rot_first%0d got=start%b ch%0d exp=start1 ch%0d", f, pulse_start, pulse_ch, exp_ch);
      end
    end
    enable = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid_gap();
    int fs; bit ok;
    do_reset();
    frame_period = 12'd199; gap = 4'd4; eng_d = 10; ch_enable = 4'hF; enable = 1'b1;
    wait_fs(fs, ok);
    total++; if (!ok) begin bad++; $display("FAIL rgap_frame_start got=none exp=strobe"); end
    repeat (14) @(negedge clk);
    total++; if (active !== 1'b1 || amplitude !== exp_amp(0)) begin bad++; $display("FAIL rgap_in_gap got=act%b amp%h exp=act1 amp%h", active, amplitude, exp_amp(0)); end
    resetn = 1'b0;
    #1;
    total++; if (active !== 1'b0)      begin bad++; $display("FAIL rgap_active got=%b exp=0", active); end
    total++; if (electrode1 !== '0)    begin bad++; $display("FAIL rgap_e1 got=%h exp=0", electrode1); end
    total++; if (electrode2 !== '0)    begin bad++; $display("FAIL rgap_e2 got=%h exp=0", electrode2); end
    total++; if (amplitude !== '0)     begin bad++; $display("FAIL rgap_amp got=%h exp=0", amplitude); end
    total++; if ({pulse_start, pulse_ch, frame_start, frame_overrun} !== 5'b0) begin
      bad++; $display("FAIL rgap_ctrl got=%b exp=00000", {pulse_start, pulse_ch, frame_start, frame_overrun});
    end
    @(negedge clk);
    resetn = 1'b1;
    clear_log();
    repeat (150) @(negedge clk);
    total++; if (ps_cyc.size() !== 0) begin bad++; $display("FAIL rgap_quiet got=%0d exp=0", ps_cyc.size()); end
    wait_fs(fs, ok);
    total++; if (!ok) begin bad++; $display("FAIL rgap_next_frame got=none exp=strobe"); end
    repeat (2) @(negedge clk);
    total++; if (pulse_start !== 1'b1) begin bad++; $display("FAIL rgap_restart got=%b exp=1", pulse_start); end
    enable = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b0; ch_enable = '0; gap = '0; frame_period = '0;
    for (int i = 0; i < N_CH; i++) begin
      ch_electrode1[i*ELEC_W +: ELEC_W] = exp_e1(i);
      ch_electrode2[i*ELEC_W +: ELEC_W] = exp_e2(i);
      ch_amplitude[i*AMP_W +: AMP_W]    = exp_amp(i);
    end
    test_reset();
    test_all_channels();
    test_sparse();
    test_empty_frame();
    test_overrun();
    test_enable_drop();
    test_rotation();
    test_reset_mid_gap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
